// File: rtl/usb_sniffer_pkg.sv
// Shared USB sniffer definitions: speed codes, UTMI control encodings and
// the speed-to-transceiver mapping used by the reconfiguration sequencer.
package usb_sniffer_pkg;

    localparam logic [1:0] USB_SPEED_LS    = 2'd0;
    localparam logic [1:0] USB_SPEED_FS    = 2'd1;
    localparam logic [1:0] USB_SPEED_HS    = 2'd2;
    localparam logic [1:0] USB_SPEED_RESET = 2'd3;

    localparam logic [1:0] XCVR_HS = 2'b00;
    localparam logic [1:0] XCVR_FS = 2'b01;
    localparam logic [1:0] XCVR_LS = 2'b10;

    localparam logic [1:0] OPMODE_NON_DRIVING = 2'b01;

    // Returns {xcvr_select, term_select}; bus reset keeps the FS receiver up.
    function automatic logic [2:0] speed_to_utmi(input logic [1:0] speed);
        logic [2:0] utmi;
        case (speed)
            USB_SPEED_LS: utmi = {XCVR_LS, 1'b1};
            USB_SPEED_FS: utmi = {XCVR_FS, 1'b1};
            USB_SPEED_HS: utmi = {XCVR_HS, 1'b0};
            default:      utmi = {XCVR_FS, 1'b1};
        endcase
        return utmi;
    endfunction

endpackage

// File: rtl/xcvr_speed_ctrl.sv
// Sequences UTMI transceiver reconfiguration on bus speed changes: pause
// capture, drain the in-flight packet, apply, settle, then post an event.
module xcvr_speed_ctrl
    import usb_sniffer_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 120,
    parameter int unsigned DRAIN_TIMEOUT = 4095
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] det_speed_i,
    input  logic       manual_en_i,
    input  logic [1:0] manual_speed_i,
    input  logic       rx_active_i,
    output logic [1:0] xcvr_select_o,
    output logic       term_select_o,
    output logic [1:0] op_mode_o,
    output logic       capture_en_o,
    output logic [1:0] speed_o,
    output logic       evt_valid_o,
    output logic [1:0] evt_speed_o,
    input  logic       evt_ready_i
);

    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES) + 1;
    localparam int unsigned DRAIN_W  = $clog2(DRAIN_TIMEOUT) + 1;
    localparam int unsigned CNT_W    = (SETTLE_W > DRAIN_W) ? SETTLE_W : DRAIN_W;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DRAIN  = 3'd1;
    localparam logic [2:0] ST_APPLY  = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_NOTIFY = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       target;
    logic [1:0]       tgt_q;
    logic [2:0]       utmi_next;

    assign target    = manual_en_i ? manual_speed_i : det_speed_i;
    assign utmi_next = speed_to_utmi(tgt_q);
    assign op_mode_o = OPMODE_NON_DRIVING;

    // Target is sampled only in IDLE; anything that moves later is picked
    // up by the next IDLE visit, so only the final value produces an event.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= ST_SETTLE;
            cnt           <= '0;
            tgt_q         <= USB_SPEED_RESET;
            speed_o       <= USB_SPEED_RESET;
            xcvr_select_o <= XCVR_FS;
            term_select_o <= 1'b1;
            capture_en_o  <= 1'b0;
            evt_valid_o   <= 1'b0;
            evt_speed_o   <= USB_SPEED_RESET;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (target != speed_o) begin
                        tgt_q        <= target;
                        cnt          <= '0;
                        capture_en_o <= 1'b0;
                        state        <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!rx_active_i || (cnt == DRAIN_LAST)) begin
                        state <= ST_APPLY;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_APPLY: begin
                    speed_o       <= tgt_q;
                    xcvr_select_o <= utmi_next[2:1];
                    term_select_o <= utmi_next[0];
                    cnt           <= '0;
                    state         <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        capture_en_o <= 1'b1;
                        evt_valid_o  <= 1'b1;
                        evt_speed_o  <= speed_o;
                        state        <= ST_NOTIFY;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_NOTIFY: begin
                    if (evt_ready_i) begin
                        evt_valid_o <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xcvr_speed_ctrl.sv
// Directed bench for xcvr_speed_ctrl: reset sequence, speed changes, drain
// delay and timeout, manual override, mid-settle changes, stall and reset.
module tb_xcvr_speed_ctrl;

    localparam int unsigned S = 20;
    localparam int unsigned T = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] det;
    logic       manual_en;
    logic [1:0] manual;
    logic       rx;
    logic [1:0] xcvr;
    logic       term;
    logic [1:0] op_mode;
    logic       capture;
    logic [1:0] speed;
    logic       evt_valid;
    logic [1:0] evt_speed;
    logic       ready;

    int total = 0;
    int bad   = 0;

    xcvr_speed_ctrl #(
        .SETTLE_CYCLES(S),
        .DRAIN_TIMEOUT(T)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .det_speed_i    (det),
        .manual_en_i    (manual_en),
        .manual_speed_i (manual),
        .rx_active_i    (rx),
        .xcvr_select_o  (xcvr),
        .term_select_o  (term),
        .op_mode_o      (op_mode),
        .capture_en_o   (capture),
        .speed_o        (speed),
        .evt_valid_o    (evt_valid),
        .evt_speed_o    (evt_speed),
        .evt_ready_i    (ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reset must be released between edges before calling.
    task automatic after_reset_check();
        repeat (S - 1) step();
        chk("rst_settle_cap", {15'd0, capture}, 16'd0);
        chk("rst_settle_evt", {15'd0, evt_valid}, 16'd0);
        step();
        chk("rst_evt_cap", {15'd0, capture}, 16'd1);
        chk("rst_evt_valid", {15'd0, evt_valid}, 16'd1);
        chk("rst_evt_speed", {14'd0, evt_speed}, 16'd3);
        chk("rst_evt_xcvr", {14'd0, xcvr}, 16'h1);
        chk("rst_evt_term", {15'd0, term}, 16'd1);
    endtask

    // Called with the new target already driven while the DUT sits in IDLE.
    task automatic seq(input logic [1:0] spd, input logic [1:0] xs, input logic ts,
                       input logic [1:0] old_spd, input int extra, input bit release_rx);
        step();
        chk("seq_cap_fall", {15'd0, capture}, 16'd0);
        chk("seq_drain_speed", {14'd0, speed}, {14'd0, old_spd});
        for (int i = 0; i < extra; i++) step();
        if (release_rx) rx = 1'b0;
        step();
        chk("seq_apply_speed_old", {14'd0, speed}, {14'd0, old_spd});
        step();
        chk("seq_speed", {14'd0, speed}, {14'd0, spd});
        chk("seq_xcvr", {14'd0, xcvr}, {14'd0, xs});
        chk("seq_term", {15'd0, term}, {15'd0, ts});
        chk("seq_cap_low", {15'd0, capture}, 16'd0);
        repeat (S - 1) step();
        chk("seq_settle_cap", {15'd0, capture}, 16'd0);
        chk("seq_settle_evt", {15'd0, evt_valid}, 16'd0);
        step();
        chk("seq_cap_rise", {15'd0, capture}, 16'd1);
        chk("seq_evt_valid", {15'd0, evt_valid}, 16'd1);
        chk("seq_evt_speed", {14'd0, evt_speed}, {14'd0, spd});
    endtask

    task automatic handshake();
        step();
        chk("hs_evt_clear", {15'd0, evt_valid}, 16'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        det       = 2'd3;
        manual_en = 1'b0;
        manual    = 2'd0;
        rx        = 1'b0;
        ready     = 1'b1;
        repeat (3) step();
        chk("reset_cap", {15'd0, capture}, 16'd0);
        chk("reset_speed", {14'd0, speed}, 16'd3);
        chk("reset_xcvr", {14'd0, xcvr}, 16'h1);
        chk("reset_term", {15'd0, term}, 16'd1);
        chk("reset_opmode", {14'd0, op_mode}, 16'h1);
        chk("reset_evt_valid", {15'd0, evt_valid}, 16'd0);
        chk("reset_evt_speed", {14'd0, evt_speed}, 16'd3);
        rst_n = 1'b1;
        after_reset_check();
        handshake();

        // RESET -> HS, no packet in flight
        det = 2'd2;
        seq(2'd2, 2'b00, 1'b0, 2'd3, 0, 1'b1);
        handshake();

        // HS -> FS with a 50-cycle packet draining
        det = 2'd1;
        rx  = 1'b1;
        seq(2'd1, 2'b01, 1'b1, 2'd2, 50, 1'b1);
        handshake();

        // FS -> HS with rx stuck high: forced after T drain cycles
        det = 2'd2;
        rx  = 1'b1;
        seq(2'd2, 2'b00, 1'b0, 2'd1, T - 1, 1'b0);
        rx = 1'b0;
        handshake();

        // manual override to LS and back
        manual_en = 1'b1;
        manual    = 2'd0;
        seq(2'd0, 2'b10, 1'b1, 2'd2, 0, 1'b1);
        handshake();
        manual_en = 1'b0;
        seq(2'd2, 2'b00, 1'b0, 2'd0, 0, 1'b1);
        handshake();

        // HS -> FS, then det moves 2 -> 0 during SETTLE
        det = 2'd1;
        step();
        step();
        step();
        chk("mid_speed_fs", {14'd0, speed}, 16'd1);
        repeat (5) step();
        det = 2'd2;
        repeat (5) step();
        det = 2'd0;
        repeat (S - 11) step();
        chk("mid_settle_evt", {15'd0, evt_valid}, 16'd0);
        chk("mid_speed_hold", {14'd0, speed}, 16'd1);
        step();
        chk("mid_evt_valid", {15'd0, evt_valid}, 16'd1);
        chk("mid_evt_speed", {14'd0, evt_speed}, 16'd1);
        handshake();
        seq(2'd0, 2'b10, 1'b1, 2'd1, 0, 1'b1);
        handshake();

        // target equals applied speed: no further activity
        repeat (10) step();
        chk("idle_cap", {15'd0, capture}, 16'd1);
        chk("idle_evt", {15'd0, evt_valid}, 16'd0);
        chk("idle_speed", {14'd0, speed}, 16'd0);

        // consumer stalls for 100 cycles in NOTIFY
        ready = 1'b0;
        det   = 2'd1;
        seq(2'd1, 2'b01, 1'b1, 2'd0, 0, 1'b1);
        for (int i = 0; i < 100; i++) begin
            step();
            chk("stall_evt_valid", {15'd0, evt_valid}, 16'd1);
            chk("stall_evt_speed", {14'd0, evt_speed}, 16'd1);
            chk("stall_cap", {15'd0, capture}, 16'd1);
        end
        ready = 1'b1;
        handshake();

        // reset pulse mid-SETTLE
        det = 2'd2;
        step();
        step();
        step();
        chk("pre_rst_speed", {14'd0, speed}, 16'd2);
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        chk("async_rst_cap", {15'd0, capture}, 16'd0);
        chk("async_rst_speed", {14'd0, speed}, 16'd3);
        chk("async_rst_xcvr", {14'd0, xcvr}, 16'h1);
        chk("async_rst_term", {15'd0, term}, 16'd1);
        chk("async_rst_evt", {15'd0, evt_valid}, 16'd0);
        chk("async_rst_evt_speed", {14'd0, evt_speed}, 16'd3);
        #2;
        rst_n = 1'b1;
        after_reset_check();
        handshake();
        seq(2'd2, 2'b00, 1'b0, 2'd3, 0, 1'b1);
        handshake();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
